stat_counter_bank: RTL and testbench

//   Parametrised bank of CHANNELS independent event counters for CPU statistics
//   (cycles, retired instructions, taken branches, stalls). Generalises the single

---
 rtl/stat_counter_bank_if.sv | 29 ++
 rtl/stat_counter_bank.sv | 88 ++++++++
 tb/tb_stat_counter_bank.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stat_counter_bank_if.sv
// Control/read bundle for stat_counter_bank: count strobes, load/clear/snapshot
// controls and the registered read port with the sticky overflow flags.
interface stat_counter_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int SEL_W    = 2
);
    logic                enable;
    logic [CHANNELS-1:0] inc;
    logic                clear;
    logic                load;
    logic [SEL_W-1:0]    load_sel;
    logic [WIDTH-1:0]    load_data;
    logic                snapshot;
    logic                rd_src;
    logic [SEL_W-1:0]    rd_sel;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output enable, inc, clear, load, load_sel, load_data, snapshot, rd_src, rd_sel,
        input  rd_data, ovf
    );

    modport slave (
        input  enable, inc, clear, load, load_sel, load_data, snapshot, rd_src, rd_sel,
        output rd_data, ovf
    );
endinterface

// File: rtl/stat_counter_bank.sv
// Bank of independent event counters with wrap/saturate mode, sticky overflow,
// atomic snapshot and a registered read port.
module stat_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    stat_counter_bank_if.slave  bus
);
    typedef logic [WIDTH-1:0] word_t;

    localparam word_t ZERO_C = {WIDTH{1'b0}};
    localparam word_t MAX_C  = {WIDTH{1'b1}};
    localparam word_t ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    word_t               cnt_r      [CHANNELS];
    word_t               snap_r     [CHANNELS];
    word_t               cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0] ovf_r;
    logic [CHANNELS-1:0] ovf_next_s;
    word_t               rd_data_r;
    word_t               rd_next_s;

    // Per-channel next state: clear > load of this channel > enabled increment > hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next_s[i] = cnt_r[i];
            ovf_next_s[i] = ovf_r[i];
            if (bus.clear) begin
                cnt_next_s[i] = ZERO_C;
                ovf_next_s[i] = 1'b0;
            end else if (bus.load && (bus.load_sel == SEL_W'(i))) begin
                cnt_next_s[i] = bus.load_data;
                ovf_next_s[i] = 1'b0;
            end else if (bus.enable && bus.inc[i]) begin
                if (cnt_r[i] == MAX_C) begin
                    cnt_next_s[i] = (SATURATE != 0) ? MAX_C : ZERO_C;
                    ovf_next_s[i] = 1'b1;
                end else begin
                    cnt_next_s[i] = cnt_r[i] + ONE_C;
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Read mux over pre-edge state; a select beyond the last channel reads zero.
    always_comb begin
        rd_next_s = ZERO_C;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_next_s = bus.rd_src ? snap_r[i] : cnt_r[i];
            end else begin
                rd_next_s = rd_next_s;
            end
        end
    end

    // State registers; the snapshot copies pre-edge counts so read-and-clear is atomic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]  <= ZERO_C;
                snap_r[i] <= ZERO_C;
            end
            ovf_r     <= {CHANNELS{1'b0}};
            rd_data_r <= ZERO_C;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
                if (bus.snapshot) begin
                    snap_r[i] <= cnt_r[i];
                end else begin
                    snap_r[i] <= snap_r[i];
                end
            end
            ovf_r     <= ovf_next_s;
            rd_data_r <= rd_next_s;
        end
    end

    assign bus.rd_data = rd_data_r;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_stat_counter_bank.sv
// Directed bench for stat_counter_bank: three instances cover wrap, saturate/3-channel
// and default-width configurations with hand-computed expected values.
module tb_stat_counter_bank;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    stat_counter_bank_if #(.CHANNELS(4), .WIDTH(4),  .SEL_W(2)) bus_w ();
    stat_counter_bank_if #(.CHANNELS(3), .WIDTH(4),  .SEL_W(2)) bus_s ();
    stat_counter_bank_if #(.CHANNELS(4), .WIDTH(32), .SEL_W(2)) bus_d ();

    stat_counter_bank #(.CHANNELS(4), .WIDTH(4), .SATURATE(0), .SEL_W(2)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w.slave));
    stat_counter_bank #(.CHANNELS(3), .WIDTH(4), .SATURATE(1), .SEL_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave));
    stat_counter_bank #(.CHANNELS(4), .WIDTH(32), .SATURATE(0), .SEL_W(2)) dut_d (
        .clk(clk), .rst(rst), .bus(bus_d.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        {bus_w.enable, bus_w.inc, bus_w.clear, bus_w.load, bus_w.load_sel, bus_w.load_data,
         bus_w.snapshot, bus_w.rd_src, bus_w.rd_sel} = '0;
        {bus_s.enable, bus_s.inc, bus_s.clear, bus_s.load, bus_s.load_sel, bus_s.load_data,
         bus_s.snapshot, bus_s.rd_src, bus_s.rd_sel} = '0;
        {bus_d.enable, bus_d.inc, bus_d.clear, bus_d.load, bus_d.load_sel, bus_d.load_data,
         bus_d.snapshot, bus_d.rd_src, bus_d.rd_sel} = '0;
        #12;
        check_eq("reset_rd", 64'(bus_d.rd_data), 64'd0);
        check_eq("reset_ovf", 64'(bus_d.ovf), 64'd0);
        rst = 1'b0;

        // 1: reset mid-count
        bus_d.enable = 1'b1;
        bus_d.inc    = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        check_eq("cnt_before_rst", 64'(bus_d.rd_data), 64'd4);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_rd", 64'(bus_d.rd_data), 64'd0);
        check_eq("async_rst_ovf", 64'(bus_d.ovf), 64'd0);
        #1 rst = 1'b0;
        tick();
        check_eq("post_rst_cnt0", 64'(bus_d.rd_data), 64'd0);
        bus_d.inc = 4'b0000;
        tick();
        check_eq("post_rst_cnt1", 64'(bus_d.rd_data), 64'd1);

        // 2: wrap, sticky ovf, load clears ovf, load beats overflowing increment
        bus_w.load = 1'b1; bus_w.load_sel = 2'd1; bus_w.load_data = 4'd14;
        tick();
        bus_w.load = 1'b0;
        bus_w.enable = 1'b1; bus_w.inc = 4'b0010; bus_w.rd_sel = 2'd1;
        tick();
        check_eq("wrap_e1_rd", 64'(bus_w.rd_data), 64'd14);
        check_eq("wrap_e1_ovf", 64'(bus_w.ovf), 64'd0);
        tick();
        check_eq("wrap_e2_rd", 64'(bus_w.rd_data), 64'd15);
        check_eq("wrap_e2_ovf", 64'(bus_w.ovf), 64'b0010);
        tick();
        check_eq("wrap_e3_rd", 64'(bus_w.rd_data), 64'd0);
        bus_w.inc = 4'b0000;
        tick();
        check_eq("wrap_e4_rd", 64'(bus_w.rd_data), 64'd1);
        tick();
        check_eq("ovf_sticky", 64'(bus_w.ovf), 64'b0010);
        bus_w.load = 1'b1; bus_w.load_data = 4'd15;
        tick();
        check_eq("load_clr_ovf", 64'(bus_w.ovf), 64'd0);
        bus_w.load_data = 4'd5; bus_w.inc = 4'b0010;
        tick();
        bus_w.load = 1'b0; bus_w.inc = 4'b0000;
        check_eq("load_vs_wrap_ovf", 64'(bus_w.ovf), 64'd0);
        tick();
        check_eq("load_vs_wrap_cnt", 64'(bus_w.rd_data), 64'd5);

        // 4: priority
        bus_w.load = 1'b1; bus_w.load_sel = 2'd0; bus_w.load_data = 4'd9;
        tick();
        bus_w.clear = 1'b1; bus_w.load_data = 4'd7; bus_w.inc = 4'b1111;
        tick();
        bus_w.clear = 1'b0; bus_w.load = 1'b0; bus_w.inc = 4'b0000; bus_w.rd_sel = 2'd0;
        tick();
        check_eq("clr_prio_ch0", 64'(bus_w.rd_data), 64'd0);
        bus_w.rd_sel = 2'd1;
        tick();
        check_eq("clr_prio_ch1", 64'(bus_w.rd_data), 64'd0);
        bus_w.rd_sel = 2'd0; bus_w.load = 1'b1; bus_w.load_data = 4'd7; bus_w.inc = 4'b0001;
        tick();
        bus_w.load = 1'b0; bus_w.inc = 4'b0000;
        tick();
        check_eq("load_prio_inc", 64'(bus_w.rd_data), 64'd7);
        bus_w.enable = 1'b0; bus_w.inc = 4'b1111;
        tick();
        tick();
        check_eq("enable_gate", 64'(bus_w.rd_data), 64'd7);
        bus_w.inc = 4'b0000;

        // 3: saturate on a 3-channel bank
        bus_s.load = 1'b1; bus_s.load_sel = 2'd2; bus_s.load_data = 4'd14;
        tick();
        bus_s.load = 1'b0; bus_s.enable = 1'b1; bus_s.inc = 3'b100; bus_s.rd_sel = 2'd2;
        tick();
        check_eq("sat_e1_rd", 64'(bus_s.rd_data), 64'd14);
        check_eq("sat_e1_ovf", 64'(bus_s.ovf), 64'd0);
        tick();
        check_eq("sat_e2_rd", 64'(bus_s.rd_data), 64'd15);
        check_eq("sat_e2_ovf", 64'(bus_s.ovf), 64'b100);
        tick();
        tick();
        bus_s.inc = 3'b000;
        tick();
        check_eq("sat_hold_rd", 64'(bus_s.rd_data), 64'd15);
        check_eq("sat_ovf_only2", 64'(bus_s.ovf), 64'b100);

        // 6: read edge cases
        bus_s.rd_sel = 2'd3;
        tick();
        check_eq("rd_sel_oob", 64'(bus_s.rd_data), 64'd0);
        bus_s.load = 1'b1; bus_s.load_sel = 2'd3; bus_s.load_data = 4'd9;
        tick();
        bus_s.load = 1'b0; bus_s.rd_sel = 2'd0;
        tick();
        check_eq("oob_load_ch0", 64'(bus_s.rd_data), 64'd0);
        bus_s.rd_sel = 2'd1;
        tick();
        check_eq("oob_load_ch1", 64'(bus_s.rd_data), 64'd0);
        bus_s.rd_sel = 2'd2;
        tick();
        check_eq("oob_load_ch2", 64'(bus_s.rd_data), 64'd15);
        check_eq("oob_load_ovf", 64'(bus_s.ovf), 64'b100);
        bus_s.rd_sel = 2'd0;
        #1;
        check_eq("rd_lag_hold", 64'(bus_s.rd_data), 64'd15);
        tick();
        check_eq("rd_lag_next", 64'(bus_s.rd_data), 64'd0);

        // 5: snapshot with clear and increment on the same edge
        bus_d.enable = 1'b1;
        bus_d.load = 1'b1; bus_d.load_sel = 2'd3; bus_d.load_data = 32'd100;
        tick();
        bus_d.load = 1'b0; bus_d.snapshot = 1'b1; bus_d.clear = 1'b1; bus_d.inc = 4'b1000;
        tick();
        bus_d.snapshot = 1'b0; bus_d.clear = 1'b0; bus_d.inc = 4'b0000;
        bus_d.rd_src = 1'b1; bus_d.rd_sel = 2'd3;
        tick();
        check_eq("snap_pre_clear", 64'(bus_d.rd_data), 64'd100);
        bus_d.rd_src = 1'b0;
        tick();
        check_eq("cnt_after_clear", 64'(bus_d.rd_data), 64'd0);
        bus_d.load = 1'b1; bus_d.load_sel = 2'd2; bus_d.load_data = 32'd50;
        tick();
        bus_d.load = 1'b0; bus_d.snapshot = 1'b1; bus_d.inc = 4'b0100;
        tick();
        bus_d.snapshot = 1'b0; bus_d.inc = 4'b0000; bus_d.rd_src = 1'b1; bus_d.rd_sel = 2'd2;
        tick();
        check_eq("snap_pre_inc", 64'(bus_d.rd_data), 64'd50);
        bus_d.rd_src = 1'b0;
        tick();
        check_eq("cnt_post_inc", 64'(bus_d.rd_data), 64'd51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
